if_stage: RTL
=============

// Module: if_stage
// PURPOSE
//   Instruction-fetch stage of the 16-bit pipelined CPU: owns the PC register, the PC+2 adder,
//   the instruction-memory request and the IF/ID pipeline register. It feeds the decode stage.
//   It handles downstream stalls, branch/jump redirects, flushes and instruction-memory wait
//   cycles. The top level exposes pc_o / pc_plus_o as PCOutput / IFAdderOutput and
//   ifid_instr_o as Instruction.
// PARAMETERS
//   DATA_W    16       width of PC, address and instruction
//   RESET_PC  16'h0000 PC value loaded on reset
//   PC_INC    2        byte increment per sequential fetch
// PORTS
//   clk            in   1       system clock, rising edge
//   reset_n        in   1       asynchronous, active-low reset
//   stall_i        in   1       decode/hazard unit: hold PC and IF/ID this cycle
//   flush_i        in   1       kill the IF/ID contents (insert bubble)
//   redirect_i     in   1       taken branch/jump: load redirect_pc_i into PC
//   redirect_pc_i  in   DATA_W  redirect target
//   imem_req_o     out  1       fetch request valid
//   imem_addr_o    out  DATA_W  fetch address (= pc_o)
//   imem_rdata_i   in   DATA_W  instruction returned by memory
//   imem_valid_i   in   1       imem_rdata_i valid this cycle (same-cycle response)
//   pc_o           out  DATA_W  current PC
//   pc_plus_o      out  DATA_W  pc_o + PC_INC (combinational)
//   ifid_instr_o   out  DATA_W  IF/ID instruction register
//   ifid_pc_plus_o out  DATA_W  IF/ID copy of PC+PC_INC of that instruction
//   ifid_valid_o   out  1       IF/ID holds a live instruction
// BEHAVIOUR
//   Reset (async, reset_n=0): pc=RESET_PC, ifid_instr=NOP (16'h0000), ifid_pc_plus=0,
//     ifid_valid=0, state=BOOT, imem_req_o=0. Perf counters (if present) = 0.
//   FSM states and transitions:
//     BOOT: first edge after reset release -> RUN; no request is issued and PC is held.
//     RUN:  imem_req_o=1. If imem_valid_i=0 -> WAIT.
//     WAIT: imem_req_o=1. If imem_valid_i=1 -> RUN.
//   Per-edge priority in RUN/WAIT: redirect_i > flush_i > stall_i > miss > advance.
//     redirect_i: pc<=redirect_pc_i; IF/ID<=NOP, valid 0; state<=RUN. Any pending miss is abandoned.
//     flush_i (no redirect): IF/ID<=NOP, valid 0. PC advances only if imem_valid_i=1 and !stall_i.
//     stall_i: PC and IF/ID hold their values; the fetched data is discarded and re-fetched later.
//     miss (imem_valid_i=0): PC holds; IF/ID<=NOP, valid 0 (bubble).
//     advance: IF/ID<={imem_rdata_i, pc+PC_INC}, valid 1; pc<=pc+PC_INC.
//   Latency: an instruction appears on ifid_instr_o one edge after its address is on imem_addr_o.
//   Arithmetic: pc_plus_o = (pc + PC_INC) mod 2^DATA_W. 16'hFFFE wraps to 16'h0000, with no flag.
//   Redirect target bit0 is used as given; alignment checks belong to the EX stage.
//   Redirect in BOOT is ignored. Reset mid-fetch returns everything to reset values immediately.
// CONFIGURATION
//   IF_PERF_CNT_EN defined: adds outputs perf_stall_cnt_o[15:0] and perf_miss_cnt_o[15:0].
//     perf_stall_cnt_o counts edges with stall_i && !redirect_i.
//     perf_miss_cnt_o counts edges spent in WAIT plus RUN->WAIT transitions.
//     Both counters saturate at 16'hFFFF.
//   Not defined: the ports and counters are absent. Fetch behaviour is identical.
// STRUCTURE
//   Shared header cpu_defs.v: DATA_W, NOP_INSTR (16'h0000), PC_INC, and the if_stage state
//     encodings (IF_BOOT=2'd0, IF_RUN=2'd1, IF_WAIT=2'd2).
//   Sub-module pc_adder (DATA_W-bit combinational a+PC_INC) drives pc_plus_o. The FSM, the PC
//     register and IF/ID live in if_stage.
// TESTING
//   1. reset_n=0 for 20 ns, then 1 with imem_valid_i=1 held:
//      pc_o sequence 0000 (BOOT), 0000, 0002, 0004; ifid_valid_o rises on the 2nd post-reset edge.
//   2. Memory returns 16'h1234 @0002 and 16'h5678 @0004:
//      ifid_instr_o = 1234 then 5678; ifid_pc_plus_o = 0004 then 0006.
//   3. stall_i high 3 cycles at pc=0006:
//      pc_o stays 0006 and IF/ID is unchanged for 3 edges; resumes at 0008.
//      With IF_PERF_CNT_EN, perf_stall_cnt_o = 3.
//   4. redirect_i=1 with redirect_pc_i=16'h0040 and stall_i=1 on the same edge:
//      pc_o=0040, ifid_valid_o=0; the next edge fetches 0040.
//   5. imem_valid_i=0 for 2 cycles at pc=0010:
//      state goes to WAIT, two bubbles, pc_o holds 0010.
//      Then data is captured, pc_o=0012, and perf_miss_cnt_o=2.
//   6. redirect to 16'hFFFE, then free run:
//      pc_o FFFE -> 0000 wrap; pc_plus_o=0000 while pc_o=FFFE.
//      Then assert reset_n=0 mid-fetch: all outputs take reset values asynchronously.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage of the 16-bit pipelined CPU.
//   DATA_W     : width of PC, address and instruction
//   NOP_INSTR  : encoding inserted as a pipeline bubble
//   PC_INC     : byte increment per sequential fetch
//   if_state_t : fetch FSM states (BOOT=0, RUN=1, WAIT=2)
package if_stage_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam logic [15:0] NOP_INSTR = 16'h0000;
  localparam int unsigned PC_INC    = 2;

  typedef enum logic [1:0] {
    IF_BOOT = 2'd0,
    IF_RUN  = 2'd1,
    IF_WAIT = 2'd2
  } if_state_t;

endpackage

// File: rtl/if_stage_pc_adder.sv
// pc_adder: combinational PC incrementer, o_sum = (i_a + PC_INC) mod 2^DATA_W.
// Wraps silently (16'hFFFE + 2 -> 16'h0000), no carry flag.
// Ports:
//   i_a   in  DATA_W  current PC
//   o_sum out DATA_W  incremented PC
module pc_adder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PC_INC = 2
) (
  input  logic [DATA_W-1:0] i_a,
  output logic [DATA_W-1:0] o_sum
);

  assign o_sum = i_a + DATA_W'(PC_INC);

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage. Owns the PC register, the PC+PC_INC adder,
// the instruction-memory request and the IF/ID pipeline register.
// Optional feature macro: IF_PERF_CNT_EN (adds saturating stall/miss counters).
// Ports:
//   clk, reset_n        clock (rising edge), async active-low reset
//   stall_i             hold PC and IF/ID this cycle
//   flush_i             replace IF/ID with a bubble
//   redirect_i          load redirect_pc_i into PC (taken branch/jump)
//   redirect_pc_i       redirect target (bit0 used as given)
//   imem_req_o          fetch request valid
//   imem_addr_o         fetch address (= pc_o)
//   imem_rdata_i        instruction from memory
//   imem_valid_i        imem_rdata_i valid this cycle (same-cycle response)
//   pc_o, pc_plus_o     current PC and PC+PC_INC (combinational)
//   ifid_instr_o        IF/ID instruction
//   ifid_pc_plus_o      IF/ID PC+PC_INC of that instruction
//   ifid_valid_o        IF/ID holds a live instruction
//   perf_stall_cnt_o    (IF_PERF_CNT_EN) edges with stall_i && !redirect_i
//   perf_miss_cnt_o     (IF_PERF_CNT_EN) edges ending in WAIT
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned       DATA_W   = if_stage_pkg::DATA_W,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_INC   = if_stage_pkg::PC_INC
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              redirect_i,
  input  logic [DATA_W-1:0] redirect_pc_i,
  output logic              imem_req_o,
  output logic [DATA_W-1:0] imem_addr_o,
  input  logic [DATA_W-1:0] imem_rdata_i,
  input  logic              imem_valid_i,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] pc_plus_o,
  output logic [DATA_W-1:0] ifid_instr_o,
  output logic [DATA_W-1:0] ifid_pc_plus_o,
  output logic              ifid_valid_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0]       perf_stall_cnt_o,
  output logic [15:0]       perf_miss_cnt_o
`endif
);

  localparam logic [DATA_W-1:0] NOP_W = DATA_W'(NOP_INSTR);

  if_state_t         r_state, w_state_next;
  logic [DATA_W-1:0] r_pc, w_pc_next, w_pc_plus;
  logic [DATA_W-1:0] r_ifid_instr, w_ifid_instr_next;
  logic [DATA_W-1:0] r_ifid_pc_plus, w_ifid_pc_plus_next;
  logic              r_ifid_valid, w_ifid_valid_next;
  logic              w_req;

  pc_adder #(
    .DATA_W (DATA_W),
    .PC_INC (PC_INC)
  ) u_pc_adder (
    .i_a   (r_pc),
    .o_sum (w_pc_plus)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IF_BOOT;
      r_pc           <= RESET_PC;
      r_ifid_instr   <= NOP_W;
      r_ifid_pc_plus <= '0;
      r_ifid_valid   <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_pc           <= w_pc_next;
      r_ifid_instr   <= w_ifid_instr_next;
      r_ifid_pc_plus <= w_ifid_pc_plus_next;
      r_ifid_valid   <= w_ifid_valid_next;
    end
  end

  // Priority per edge: redirect > flush > stall > miss > advance.
  always_comb begin
    w_state_next        = r_state;
    w_pc_next           = r_pc;
    w_ifid_instr_next   = r_ifid_instr;
    w_ifid_pc_plus_next = r_ifid_pc_plus;
    w_ifid_valid_next   = r_ifid_valid;
    w_req               = 1'b0;
    unique case (r_state)
      IF_BOOT: begin
        // No request, PC held, redirect ignored.
        w_state_next = IF_RUN;
      end
      IF_RUN, IF_WAIT: begin
        w_req        = 1'b1;
        w_state_next = imem_valid_i ? IF_RUN : IF_WAIT;
        if (redirect_i) begin
          // Abandons any outstanding miss.
          w_state_next        = IF_RUN;
          w_pc_next           = redirect_pc_i;
          w_ifid_instr_next   = NOP_W;
          w_ifid_pc_plus_next = '0;
          w_ifid_valid_next   = 1'b0;
        end else if (flush_i) begin
          w_ifid_instr_next   = NOP_W;
          w_ifid_pc_plus_next = '0;
          w_ifid_valid_next   = 1'b0;
          if (imem_valid_i && !stall_i) begin
            w_pc_next = w_pc_plus;
          end
        end else if (stall_i) begin
          // Hold; returned data is dropped and re-fetched from the same PC.
        end else if (!imem_valid_i) begin
          w_ifid_instr_next   = NOP_W;
          w_ifid_pc_plus_next = '0;
          w_ifid_valid_next   = 1'b0;
        end else begin
          w_pc_next           = w_pc_plus;
          w_ifid_instr_next   = imem_rdata_i;
          w_ifid_pc_plus_next = w_pc_plus;
          w_ifid_valid_next   = 1'b1;
        end
      end
      default: begin
        w_state_next = IF_BOOT;
      end
    endcase
  end

`ifdef IF_PERF_CNT_EN
  logic [15:0] r_stall_cnt, r_miss_cnt;

  // A miss edge is one that ends in WAIT: RUN->WAIT plus WAIT->WAIT.
  // The edge that leaves WAIT on returning data is not counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_miss_cnt  <= '0;
    end else begin
      if (stall_i && !redirect_i && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if ((w_state_next == IF_WAIT) && (r_miss_cnt != '1)) begin
        r_miss_cnt <= r_miss_cnt + 16'd1;
      end
    end
  end

  assign perf_stall_cnt_o = r_stall_cnt;
  assign perf_miss_cnt_o  = r_miss_cnt;
`else
  // Fetch path only; no performance counters in this build.
`endif

  assign imem_req_o     = w_req;
  assign imem_addr_o    = r_pc;
  assign pc_o           = r_pc;
  assign pc_plus_o      = w_pc_plus;
  assign ifid_instr_o   = r_ifid_instr;
  assign ifid_pc_plus_o = r_ifid_pc_plus;
  assign ifid_valid_o   = r_ifid_valid;

endmodule
